// File: rtl/hash_result_reader_if.sv
// -----------------------------------------------------------------------------
// hash_result_reader_if
// Memory-side bus of the hash result reader. The memory returns read data
// two clock edges after the edge that registers the address.
//
// Signals:
//   mem_clk        memory clock (the reader forwards its own clock)
//   mem_we         write enable
//   mem_addr       word address, ADDR_W bits
//   mem_write_data write data, 32 bits
//   mem_read_data  read data, 32 bits
//
// Modports:
//   master  the reader (drives clock, address, write controls)
//   slave   the memory
// -----------------------------------------------------------------------------
interface hash_result_reader_if #(
    parameter int ADDR_W = 16
);
    logic              mem_clk;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport master (
        output mem_clk,
        output mem_we,
        output mem_addr,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_clk,
        input  mem_we,
        input  mem_addr,
        input  mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/hash_result_reader.sv
// -----------------------------------------------------------------------------
// hash_result_reader
// Scans NUM_NONCES consecutive 32-bit hash words starting at result_addr,
// finds the minimum (lowest index wins ties) and reports whether it is below
// the difficulty target sampled at start.
//
// Optional feature (macro HASH_STATUS_WB_EN): after the scan, write the
// status word {found, best_nonce[30:0]} to result_addr+NUM_NONCES in a
// one-cycle WB state; done then rises one cycle later.
//
// Ports:
//   clk          clock
//   reset_n      asynchronous active-low reset
//   start        begin a scan (honoured only in IDLE or DONE)
//   result_addr  base address of hash word 0
//   target       difficulty threshold (unsigned)
//   done         scan complete, held until the next start
//   found        best_hash < target
//   best_nonce   index of the minimum hash word
//   best_hash    minimum hash word value
//   mem          memory bus (hash_result_reader_if.master)
//
// NUM_NONCES must be at least 2.
// -----------------------------------------------------------------------------
module hash_result_reader #(
    parameter int NUM_NONCES = 16,
    parameter int ADDR_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     result_addr,
    input  logic [31:0]           target,
    output logic                  done,
    output logic                  found,
    output logic [31:0]           best_nonce,
    output logic [31:0]           best_hash,
    hash_result_reader_if.master  mem
);

    // r_cyc counts edges since the start edge; it must reach NUM_NONCES+1.
    localparam int CNT_W = $clog2(NUM_NONCES + 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRIME = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef HASH_STATUS_WB_EN
    localparam logic [2:0] S_WB    = 3'd5;
`endif

    localparam logic [CNT_W-1:0] CYC_LAST_ISSUE = CNT_W'(NUM_NONCES - 2);
    localparam logic [CNT_W-1:0] CYC_LAST_CAP   = CNT_W'(NUM_NONCES);
    localparam logic [CNT_W-1:0] CYC_FIRST_CMP  = CNT_W'(2);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cyc;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_target;
    logic [31:0]       r_word;
    logic              r_have;
    logic [31:0]       r_best_hash;
    logic [31:0]       r_best_nonce;
    logic              r_done;
    logic              r_found;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_cmp_en;
    logic              w_take;
    logic              w_issue_en;
    logic              w_start_ok;
    logic [31:0]       w_cmp_idx;
    logic [31:0]       w_best_hash_nxt;
    logic [31:0]       w_best_nonce_nxt;
    logic              w_found_nxt;
    logic [ADDR_W-1:0] w_issue_addr;

    // Memory clock is forwarded untouched so it runs through reset.
    assign mem.mem_clk        = clk;
    assign mem.mem_we         = r_mem_we;
    assign mem.mem_addr       = r_mem_addr;
    assign mem.mem_write_data = r_mem_wdata;

    assign done       = r_done;
    assign found      = r_found;
    assign best_nonce = r_best_nonce;
    assign best_hash  = r_best_hash;

    // Pipeline control: which address to issue and whether a captured word is compared this cycle.
    always_comb begin
        w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_issue_addr = r_base + ADDR_W'(r_cyc) + ADDR_W'(1);
        if ((r_state == S_PRIME) || (r_state == S_SCAN)) begin
            w_issue_en = (r_cyc <= CYC_LAST_ISSUE);
        end else begin
            w_issue_en = 1'b0;
        end
        // Word i is captured when r_cyc == i+1 and compared when r_cyc == i+2.
        if (r_state == S_FINAL) begin
            w_cmp_en = 1'b1;
        end else if (r_state == S_SCAN) begin
            w_cmp_en = (r_cyc >= CYC_FIRST_CMP);
        end else begin
            w_cmp_en = 1'b0;
        end
        w_cmp_idx = {{(32 - CNT_W){1'b0}}, r_cyc} - 32'd2;
    end

    // Minimum tracking: the first compared word always loads; later words only when strictly smaller.
    always_comb begin
        w_take = w_cmp_en && (!r_have || (r_word < r_best_hash));
        if (w_take) begin
            w_best_hash_nxt  = r_word;
            w_best_nonce_nxt = w_cmp_idx;
        end else begin
            w_best_hash_nxt  = r_best_hash;
            w_best_nonce_nxt = r_best_nonce;
        end
        // Found uses the post-compare minimum so the last word counts at the same edge.
        w_found_nxt = (w_best_hash_nxt < r_target);
    end

    // Scan FSM, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cyc        <= '0;
            r_base       <= '0;
            r_target     <= 32'd0;
            r_word       <= 32'd0;
            r_have       <= 1'b0;
            r_best_hash  <= 32'd0;
            r_best_nonce <= 32'd0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_base       <= result_addr;
                        r_target     <= target;
                        r_mem_addr   <= result_addr;
                        r_cyc        <= '0;
                        r_word       <= 32'd0;
                        r_have       <= 1'b0;
                        r_best_hash  <= 32'd0;
                        r_best_nonce <= 32'd0;
                        r_done       <= 1'b0;
                        r_found      <= 1'b0;
                        r_state      <= S_PRIME;
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_PRIME: begin
                    r_cyc <= r_cyc + CNT_W'(1);
                    if (w_issue_en) begin
                        r_mem_addr <= w_issue_addr;
                    end else begin
                        r_mem_addr <= r_mem_addr;
                    end
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    r_cyc        <= r_cyc + CNT_W'(1);
                    r_word       <= mem.mem_read_data;
                    r_best_hash  <= w_best_hash_nxt;
                    r_best_nonce <= w_best_nonce_nxt;
                    r_have       <= r_have | w_cmp_en;
                    if (w_issue_en) begin
                        r_mem_addr <= w_issue_addr;
                    end else begin
                        r_mem_addr <= r_mem_addr;
                    end
                    // The edge that captures the last word hands over to FINAL for its compare.
                    if (r_cyc == CYC_LAST_CAP) begin
                        r_state <= S_FINAL;
                    end else begin
                        r_state <= S_SCAN;
                    end
                end
                S_FINAL: begin
                    r_best_hash  <= w_best_hash_nxt;
                    r_best_nonce <= w_best_nonce_nxt;
                    r_have       <= 1'b1;
`ifdef HASH_STATUS_WB_EN
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_base + ADDR_W'(NUM_NONCES);
                    r_mem_wdata <= {w_found_nxt, w_best_nonce_nxt[30:0]};
                    r_state     <= S_WB;
`else
                    r_done  <= 1'b1;
                    r_found <= w_found_nxt;
                    r_state <= S_DONE;
`endif
                end
`ifdef HASH_STATUS_WB_EN
                S_WB: begin
                    // The found bit travelled in the status word's MSB.
                    r_mem_we    <= 1'b0;
                    r_mem_wdata <= 32'd0;
                    r_done      <= 1'b1;
                    r_found     <= r_mem_wdata[31];
                    r_state     <= S_DONE;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
